muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_pkg.sv | 39 +++
 rtl/muldiv_unit_step.sv | 31 +++
 rtl/muldiv_unit.sv | 123 ++++++++++++
 tb/tb_muldiv_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared types and op-decode helpers for the iterative multiply/divide unit.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op inside {DIV, DIVU, REM, REMU};
    endfunction

    function automatic logic op_a_signed(input muldiv_op_t op);
        return op inside {MUL, MULH, MULHSU, DIV, REM};
    endfunction

    function automatic logic op_b_signed(input muldiv_op_t op);
        return op inside {MUL, MULH, DIV, REM};
    endfunction

    // High product half for multiplies, remainder for divides.
    function automatic logic op_sel_hi(input muldiv_op_t op);
        return op inside {MULH, MULHSU, MULHU, REM, REMU};
    endfunction

endpackage

// File: rtl/muldiv_unit_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module muldiv_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Multiply keeps {partial, multiplier}; divide keeps {remainder, quotient}.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        diff    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
        acc_nxt = '0;
        if (!is_div) begin
            if (acc[0])
                acc_nxt = {sum, acc[WIDTH-1:1]};
            else
                acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
        end else if (diff[WIDTH]) begin
            acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M-class multiply/divide unit with valid/ready handshakes.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier for the four multiply ops.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    muldiv_state_t      state, state_nxt;
    muldiv_op_t         op_q;
    logic [2*WIDTH-1:0] acc, acc_step, prod;
    logic [WIDTH-1:0]   opnd, abs_a, abs_b, min_int, div_val, fix_res, fast_res;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q, neg_res, sa, sb, div_zero, div_ovf, fast_mul, accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & in_ready & ~flush;
    assign min_int   = {1'b1, {(WIDTH-1){1'b0}}};

    // Magnitudes and result sign are resolved at accept time.
    assign sa       = op_a_signed(op) & a[WIDTH-1];
    assign sb       = op_b_signed(op) & b[WIDTH-1];
    assign abs_a    = sa ? -a : a;
    assign abs_b    = sb ? -b : b;
    assign neg_res  = (op_is_div(op) && op_sel_hi(op)) ? sa : (sa ^ sb);
    assign div_zero = op_is_div(op) && (b == '0);
    assign div_ovf  = (op == DIV || op == REM) && (a == min_int) && (b == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [WIDTH:0]     fa, fb;
    logic signed [2*WIDTH-1:0] fprod;
    assign fa       = $signed({op_a_signed(op) & a[WIDTH-1], a});
    assign fb       = $signed({op_b_signed(op) & b[WIDTH-1], b});
    assign fprod    = (2*WIDTH)'(fa) * (2*WIDTH)'(fb);
    assign fast_res = op_sel_hi(op) ? fprod[2*WIDTH-1:WIDTH] : fprod[WIDTH-1:0];
    assign fast_mul = !op_is_div(op);
`else
    assign fast_res = '0;
    assign fast_mul = 1'b0;
`endif

    muldiv_unit_step #(.WIDTH(WIDTH)) u_step (
        .is_div (op_is_div(op_q)),
        .acc    (acc),
        .opnd   (opnd),
        .acc_nxt(acc_step)
    );

    always_comb begin
        prod    = neg_q ? -acc : acc;
        div_val = op_sel_hi(op_q) ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
        if (op_is_div(op_q))
            fix_res = neg_q ? -div_val : div_val;
        else
            fix_res = op_sel_hi(op_q) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (div_zero || div_ovf || fast_mul) ? DONE : CALC;
            CALC: if (cnt == CNT_W'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // A flushed edge never updates out, so the last presented result is kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= MUL;
            acc   <= '0;
            opnd  <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            out   <= '0;
        end else if (accept) begin
            op_q  <= op;
            neg_q <= neg_res;
            cnt   <= CNT_W'(WIDTH);
            acc   <= {{WIDTH{1'b0}}, op_is_div(op) ? abs_a : abs_b};
            opnd  <= op_is_div(op) ? abs_b : abs_a;
            if (div_zero)
                out <= op_sel_hi(op) ? a : '1;
            else if (div_ovf)
                out <= op_sel_hi(op) ? '0 : min_int;
            else if (fast_mul)
                out <= fast_res;
        end else if (!flush) begin
            if (state == CALC) begin
                acc <= acc_step;
                cnt <= cnt - CNT_W'(1);
            end
            if (state == FIX)
                out <= fix_res;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table, random ops against a
// reference model, and hand-written flush / backpressure / reset sequences.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int DIV_LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
    muldiv_op_t   op;
    logic [W-1:0] a, b, out;

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        int          lat;
        string       name;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_exp = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] ex, ey, p;
        logic        ovf;
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        ex  = (o == MULHU) ? {32'b0, x} : {{32{x[31]}}, x};
        ey  = (o == MULHSU || o == MULHU) ? {32'b0, y} : {{32{y[31]}}, y};
        p   = ex * ey;
        case (o)
            MUL:                 return p[31:0];
            MULH, MULHSU, MULHU: return p[63:32];
            DIV:  return (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
            DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            REM:  return (y == 0) ? x : ovf ? 32'h0 : 32'($signed(x) % $signed(y));
            REMU: return (y == 0) ? x : x % y;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        if (!op_is_div(o)) return MUL_LAT;
        if (y == 0) return 1;
        if ((o == DIV || o == REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
        return DIV_LAT;
    endfunction

    // Drive one request; it is accepted on the following rising edge.
    task automatic applyStimulus(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] e, input int l, input string nm);
        sb_t item;
        @(negedge clk);
        check({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        item.exp = e;
        item.lat = l;
        item.name = nm;
        sb.push_back(item);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait (bounded) for the result, compare against the scoreboard head,
    // optionally hold off the consumer, then take the result.
    task automatic checkOutput(input int hold);
        int  cyc;
        sb_t e;
        cyc = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (out_valid) break;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: empty when result expected");
            return;
        end
        e = sb.pop_front();
        check({e.name, "_valid"}, 32'(out_valid), 32'd1);
        check({e.name, "_out"}, out, e.exp);
        check({e.name, "_lat"}, 32'(cyc), 32'(e.lat));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({e.name, "_hold_out"}, out, e.exp);
            check({e.name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({e.name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({e.name, "_taken"}, 32'(out_valid), 32'd0);
        last_exp = e.exp;
    endtask

    initial begin
        int  seen;
        logic [31:0] x, y;
        muldiv_op_t  o;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = MUL; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_out", out, 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        vecs.push_back('{MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT});
        vecs.push_back('{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT});
        vecs.push_back('{MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT});
        vecs.push_back('{MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT});
        vecs.push_back('{MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MUL_LAT});
        vecs.push_back('{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT});
        vecs.push_back('{MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT});
        vecs.push_back('{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT});
        vecs.push_back('{DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT});
        vecs.push_back('{REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT});
        vecs.push_back('{DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT});
        vecs.push_back('{REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT});
        vecs.push_back('{DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT});
        vecs.push_back('{REM,    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, DIV_LAT});
        vecs.push_back('{DIV,    32'h8000_0000, 32'h0000_0002, 32'hC000_0000, DIV_LAT});
        vecs.push_back('{REMU,   32'hFFFF_FFFF, 32'd10,        32'd5,         DIV_LAT});
        vecs.push_back('{DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{REMU,   32'd100,       32'd0,         32'h0000_0064, 1});
        vecs.push_back('{DIV,    32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 1});
        vecs.push_back('{REM,    32'd5,         32'd0,         32'd5,         1});
        vecs.push_back('{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                          $sformatf("vec%0d", i));
            checkOutput(0);
        end

        for (int i = 0; i < 12; i++) begin
            o = muldiv_op_t'($urandom_range(0, 7));
            x = $urandom;
            y = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (i == 7) y = 32'h0;
            applyStimulus(o, x, y, ref_model(o, x, y), ref_lat(o, x, y), $sformatf("rand%0d", i));
            checkOutput(0);
        end

        // Flush a divide mid-calculation; the result must never appear.
        applyStimulus(DIV, 32'd1000, 32'd3, 32'd333, DIV_LAT, "flushed");
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        sb.delete();
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_valid", 32'(seen), 32'd0);
        check("flush_out_kept", out, last_exp);

        // flush together with in_valid in IDLE must not accept.
        @(negedge clk);
        op = DIVU; a = 32'd9; b = 32'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0; flush = 1'b0;
        check("flush_req_dropped", 32'(busy), 32'd0);

        applyStimulus(DIV, 32'd1000, 32'd3, 32'd333, DIV_LAT, "after_flush");
        checkOutput(0);

        // Consumer stalls for 5 cycles in DONE.
        applyStimulus(DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, "backpressure");
        checkOutput(5);

        // Async reset pulsed mid-CALC, sampled before the next rising edge.
        applyStimulus(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, "reset_mid");
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out", out, 32'h0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(MUL, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "after_reset");
        checkOutput(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
